// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the PC sequencer.
package pc_pkg;

    localparam int unsigned PC_XLEN        = 32;
    localparam int unsigned PC_INSTR_BYTES = 4;
    localparam logic [31:0] PC_RESET_VEC   = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC    = 32'h0000_0100;

    typedef enum logic [2:0] {
        NPC_RESET,
        NPC_TRAP,
        NPC_HOLD,
        NPC_RET,
        NPC_BRANCH,
        NPC_SEQ
    } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   sp;
    logic [CW-1:0]   count;
    logic [PW-1:0]   sp_inc;
    logic [PW-1:0]   sp_dec;

    // sp is the next write slot; the top lives one slot below it.
    assign sp_inc = (sp == LAST_IDX) ? '0 : sp + PW'(1);
    assign sp_dec = (sp == '0) ? LAST_IDX : sp - PW'(1);
    assign top    = mem[sp_dec];
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_CNT);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sp    <= '0;
            count <= '0;
        end else if (push && !pop) begin
            sp    <= sp_inc;
            count <= full ? count : count + CW'(1);
        end else if (pop && !push) begin
            sp    <= sp_dec;
            count <= count - CW'(1);
        end
    end

    // Pop+push replaces the top in place.
    always_ff @(posedge CLK) begin
        if (push) begin
            if (pop) mem[sp_dec] <= din;
            else     mem[sp]     <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with trap, stall, branch and optional return-address stack.
// Optional feature: define PC_SEQUENCER_RAS_EN to build in the RAS (CALL/RET).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = PC_XLEN,
    parameter int unsigned     INSTR_BYTES = PC_INSTR_BYTES,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(PC_TRAP_VEC),
    parameter int unsigned     RAS_DEPTH   = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            STALL,
    input  logic            TRAP,
    input  logic            NextPCSrc,
    input  logic [XLEN-1:0] ALURes,
    input  logic            CALL,
    input  logic            RET,
    output logic [XLEN-1:0] Pc,
    output logic [XLEN-1:0] PcPlus,
    output logic            Misalign,
    output logic            RasEmpty,
    output logic            RasFull
);

    localparam logic [XLEN-1:0] INC      = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

    npc_src_e        src;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            mis_q;
    logic            mis_d;
    logic [XLEN-1:0] ras_top;

    assign Pc       = pc_q;
    assign PcPlus   = pc_q + INC;
    assign Misalign = mis_q;

`ifdef PC_SEQUENCER_RAS_EN
    logic ras_push;
    logic ras_pop;

    assign ras_push = RESET_N && !TRAP && !STALL && CALL;
    assign ras_pop  = RESET_N && !TRAP && !STALL && RET && !RasEmpty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (PcPlus),
        .top     (ras_top),
        .empty   (RasEmpty),
        .full    (RasFull)
    );
`else
    logic unused_ras;

    assign unused_ras = ^{CALL, RET};
    assign ras_top    = '0;
    assign RasEmpty   = 1'b1;
    assign RasFull    = 1'b0;
`endif

    // Priority select of the next-PC source, then the value it implies.
    always_comb begin
        src   = NPC_SEQ;
        pc_d  = pc_q + INC;
        mis_d = 1'b0;
        if (!RESET_N)                  src = NPC_RESET;
        else if (TRAP)                 src = NPC_TRAP;
        else if (STALL)                src = NPC_HOLD;
        else if (RET && !RasEmpty)     src = NPC_RET;
        else if (NextPCSrc)            src = NPC_BRANCH;
        case (src)
            NPC_RESET:  pc_d = RESET_VEC;
            NPC_TRAP:   pc_d = TRAP_VEC;
            NPC_HOLD: begin
                pc_d  = pc_q;
                mis_d = mis_q;
            end
            NPC_RET:    pc_d = ras_top;
            NPC_BRANCH: begin
                pc_d  = ALURes & ~LOW_MASK;
                mis_d = |(ALURes & LOW_MASK);
            end
            default:    pc_d = pc_q + INC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q  <= RESET_VEC;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        STALL;
    logic        TRAP;
    logic        NextPCSrc;
    logic [31:0] ALURes;
    logic        CALL;
    logic        RET;
    logic [31:0] Pc;
    logic [31:0] PcPlus;
    logic        Misalign;
    logic        RasEmpty;
    logic        RasFull;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .STALL     (STALL),
        .TRAP      (TRAP),
        .NextPCSrc (NextPCSrc),
        .ALURes    (ALURes),
        .CALL      (CALL),
        .RET       (RET),
        .Pc        (Pc),
        .PcPlus    (PcPlus),
        .Misalign  (Misalign),
        .RasEmpty  (RasEmpty),
        .RasFull   (RasFull)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        STALL = 0; TRAP = 0; NextPCSrc = 0; ALURes = '0; CALL = 0; RET = 0;
    endtask

    task automatic jump(input logic [31:0] tgt);
        NextPCSrc = 1; ALURes = tgt;
        step();
        idle();
    endtask

    initial begin
        idle();
        RESET_N = 0;
        TRAP    = 1;
        step();
        step();
        check("reset_pc", Pc, 32'h0);
        check("reset_mis", 32'(Misalign), 32'h0);
        check("reset_empty", 32'(RasEmpty), 32'h1);
        check("reset_full", 32'(RasFull), 32'h0);
        TRAP    = 0;
        RESET_N = 1;
        step();
        check("seq_1", Pc, 32'h4);
        step();
        check("seq_2", Pc, 32'h8);
        check("pcplus", PcPlus, 32'hC);

        jump(32'h20);
        check("jump_20", Pc, 32'h20);
        check("jump_20_mis", 32'(Misalign), 32'h0);
        STALL = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", Pc, 32'h20);
        end
        TRAP = 1;
        step();
        check("stall_trap", Pc, 32'h100);
        idle();
        step();
        check("post_trap", Pc, 32'h104);

        NextPCSrc = 1; ALURes = 32'h0000_0102;
        step();
        check("br_misalign_pc", Pc, 32'h100);
        check("br_misalign_flag", 32'(Misalign), 32'h1);
        NextPCSrc = 0; STALL = 1;
        step();
        check("mis_hold_stall", 32'(Misalign), 32'h1);
        check("pc_hold_stall", Pc, 32'h100);
        STALL = 0;
        step();
        check("mis_clear", 32'(Misalign), 32'h0);
        check("seq_after_mis", Pc, 32'h104);

        jump(32'hFFFF_FFFC);
        check("wrap_pre", Pc, 32'hFFFF_FFFC);
        check("wrap_pcplus", PcPlus, 32'h0);
        step();
        check("wrap_pc", Pc, 32'h0);
        check("wrap_mis", 32'(Misalign), 32'h0);

`ifdef PC_SEQUENCER_RAS_EN
        jump(32'h10);
        for (int i = 0; i < 5; i++) begin
            CALL = 1;
            NextPCSrc = 1;
            ALURes = 32'(32'h10 * (i + 2));
            step();
            idle();
            check("call_pc", Pc, 32'(32'h10 * (i + 2)));
            check("call_full", 32'(RasFull), (i >= 3) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            RET = 1;
            step();
            check("ret_pc", Pc, 32'(32'h54 - 32'h10 * i));
        end
        check("ret_empty", 32'(RasEmpty), 32'h1);
        step();
        check("ret_ignored", Pc, 32'h28);
        idle();

        jump(32'h1FC);
        CALL = 1; NextPCSrc = 1; ALURes = 32'h80;
        step();
        idle();
        check("pre_callret", Pc, 32'h80);
        TRAP = 1; CALL = 1;
        step();
        idle();
        check("trap_no_push", Pc, 32'h100);
        jump(32'h80);
        CALL = 1; RET = 1;
        step();
        idle();
        check("callret_pc", Pc, 32'h200);
        check("callret_empty", 32'(RasEmpty), 32'h0);
        RET = 1;
        step();
        idle();
        check("callret_newtop", Pc, 32'h84);
        check("callret_count", 32'(RasEmpty), 32'h1);
`else
        jump(32'h40);
        CALL = 1; RET = 1; NextPCSrc = 1; ALURes = 32'h60;
        step();
        idle();
        check("noras_call_jump", Pc, 32'h60);
        check("noras_empty", 32'(RasEmpty), 32'h1);
        check("noras_full", 32'(RasFull), 32'h0);
        RET = 1;
        step();
        idle();
        check("noras_ret_seq", Pc, 32'h64);
`endif

        RESET_N = 0; TRAP = 1; CALL = 1; RET = 1;
        step();
        check("reset_over_trap", Pc, 32'h0);
        check("reset_over_empty", 32'(RasEmpty), 32'h1);
        idle();
        RESET_N = 1;
        step();
        check("final_seq", Pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
